// File: rtl/hdc_ctrl_pkg.sv
// Shared definitions for the HDC class-select control path: sequencer
// state encoding and default geometry of the class-HV memory.
package hdc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAIN    = 2'd1,
        BINARIZE = 2'd2,
        DONE     = 2'd3
    } seq_state_t;

    localparam int NUM_CLASSES_DEF     = 26;
    localparam int CLS_W_DEF           = 5;
    localparam int WORDS_PER_CLASS_DEF = 32;

endpackage

// File: rtl/class_binarize_sequencer_if.sv
// Valid/ready request bus from the sequencer to the class-memory binarizer.
// The sequencer drives a (class, word) address with bin_valid; the binarizer
// accepts it with bin_ready.  Widths must match the sequencer's parameters.
interface class_binarize_sequencer_if #(
    parameter int CLS_W  = 5,
    parameter int WORD_W = 5
);
    logic              bin_valid;
    logic              bin_ready;
    logic [CLS_W-1:0]  binarized_class_counter;
    logic [WORD_W-1:0] bin_word_addr;

    modport master (
        output bin_valid,
        output binarized_class_counter,
        output bin_word_addr,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  binarized_class_counter,
        input  bin_word_addr,
        output bin_ready
    );
endinterface

// File: rtl/class_binarize_sequencer_bin_addr_counter.sv
// Nested word/class address counter for the binarize sweep.  The word index
// runs fastest; the class index advances when the word index wraps.  At the
// final (class, word) pair the counter saturates so the address of the last
// transfer stays visible until the owner clears it.
module bin_addr_counter #(
    parameter int NUM_CLASSES     = 26,
    parameter int CLS_W           = 5,
    parameter int WORDS_PER_CLASS = 32,
    parameter int WORD_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic [CLS_W-1:0]  cls,
    output logic [WORD_W-1:0] word,
    output logic              last
);

    localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_CLASS - 1);

    logic last_word;

    assign last_word = (word == LAST_WORD);
    assign last      = last_word && (cls == LAST_CLS);

    // Advance word first, then class; clear wins over enable; hold at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls  <= '0;
            word <= '0;
        end else if (clr) begin
            cls  <= '0;
            word <= '0;
        end else if (en) begin
            if (!last_word) begin
                word <= word + WORD_W'(1);
            end else if (!last) begin
                word <= '0;
                cls  <= cls + CLS_W'(1);
            end
        end
    end

endmodule

// File: rtl/class_binarize_sequencer.sv
// Class-select sequencer for the class-HV memory.  Tracks the training
// phase (latching the current sample's class label) and, after the last
// training sample, sweeps every word of every class HV through the
// binarizer over a valid/ready handshake.
module class_binarize_sequencer
    import hdc_ctrl_pkg::*;
#(
    parameter int NUM_CLASSES     = NUM_CLASSES_DEF,
    parameter int CLS_W           = CLS_W_DEF,
    parameter int WORDS_PER_CLASS = WORDS_PER_CLASS_DEF,
    parameter int WORD_W          = (WORDS_PER_CLASS > 1) ? $clog2(WORDS_PER_CLASS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_train,
    input  logic                        abort,
    input  logic                        train_label_valid,
    input  logic [CLS_W-1:0]            train_label,
    input  logic                        train_last,
    class_binarize_sequencer_if.master  bin,
    output logic                        training_hdc_model,
    output logic                        binarizing_class_hvs,
    output logic [CLS_W-1:0]            class_select_bits,
    output logic                        label_err,
    output logic                        binarize_done,
    output logic                        busy
);

    // One extra bit so NUM_CLASSES == 2**CLS_W still compares correctly.
    localparam logic [CLS_W:0] NUM_CLS_EXT = (CLS_W + 1)'(NUM_CLASSES);

    seq_state_t        state;
    logic              label_ok;
    logic              cnt_en;
    logic              cnt_clr;
    logic              cnt_last;
    logic [CLS_W-1:0]  cnt_cls;
    logic [WORD_W-1:0] cnt_word;

    assign label_ok = ({1'b0, train_label} < NUM_CLS_EXT);

    // A transfer happens only while requesting; abort suppresses it.
    assign cnt_en  = (state == BINARIZE) && bin.bin_ready && !abort;
    // Final address stays visible during DONE and clears on the way to IDLE.
    assign cnt_clr = abort || (state == DONE);

    bin_addr_counter #(
        .NUM_CLASSES     (NUM_CLASSES),
        .CLS_W           (CLS_W),
        .WORDS_PER_CLASS (WORDS_PER_CLASS),
        .WORD_W          (WORD_W)
    ) u_bin_addr_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .cls   (cnt_cls),
        .word  (cnt_word),
        .last  (cnt_last)
    );

    // Phase flags and the request strobe decode straight from the state register.
    assign training_hdc_model          = (state == TRAIN);
    assign binarizing_class_hvs        = (state == BINARIZE);
    assign binarize_done               = (state == DONE);
    assign busy                        = (state != IDLE);
    assign bin.bin_valid               = (state == BINARIZE);
    assign bin.binarized_class_counter = cnt_cls;
    assign bin.bin_word_addr           = cnt_word;

    // Sequencer FSM with the registered class select and label-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            class_select_bits <= '0;
            label_err         <= 1'b0;
        end else begin
            label_err <= 1'b0;
            if (abort) begin
                state             <= IDLE;
                class_select_bits <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_train) begin
                            state <= TRAIN;
                        end
                    end
                    TRAIN: begin
                        if (train_label_valid) begin
                            if (label_ok) begin
                                class_select_bits <= train_label;
                            end else begin
                                label_err <= 1'b1;
                            end
                            if (train_last) begin
                                state <= BINARIZE;
                            end
                        end
                    end
                    BINARIZE: begin
                        if (bin.bin_ready && cnt_last) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        state             <= IDLE;
                        class_select_bits <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_class_binarize_sequencer.sv
// Directed bench for class_binarize_sequencer: a vector table for the
// training phase plus hand-written sequences for sweep, abort and reset.
module tb_class_binarize_sequencer;

    localparam int NC  = 26;
    localparam int CW  = 5;
    localparam int WPC = 4;
    localparam int WW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_train = 1'b0;
    logic          abort = 1'b0;
    logic          train_label_valid = 1'b0;
    logic [CW-1:0] train_label = '0;
    logic          train_last = 1'b0;
    logic          training_hdc_model;
    logic          binarizing_class_hvs;
    logic [CW-1:0] class_select_bits;
    logic          label_err;
    logic          binarize_done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    class_binarize_sequencer_if #(.CLS_W(CW), .WORD_W(WW)) bus ();

    class_binarize_sequencer #(
        .NUM_CLASSES     (NC),
        .CLS_W           (CW),
        .WORDS_PER_CLASS (WPC),
        .WORD_W          (WW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_train          (start_train),
        .abort                (abort),
        .train_label_valid    (train_label_valid),
        .train_label          (train_label),
        .train_last           (train_last),
        .bin                  (bus),
        .training_hdc_model   (training_hdc_model),
        .binarizing_class_hvs (binarizing_class_hvs),
        .class_select_bits    (class_select_bits),
        .label_err            (label_err),
        .binarize_done        (binarize_done),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic          ab;
        logic          vld;
        logic [CW-1:0] lbl;
        logic          lst;
        logic          rdy;
        logic          e_train;
        logic          e_bin;
        logic          e_busy;
        logic [CW-1:0] e_cls;
        logic          e_err;
        logic          e_bvalid;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_train       = 1'b0;
        abort             = 1'b0;
        train_label_valid = 1'b0;
        train_label       = '0;
        train_last        = 1'b0;
        bus.bin_ready     = 1'b0;
    endtask

    // {train, binarize, done, err, busy, bin_valid, cls_sel, counter, addr}
    function automatic logic [31:0] all_outputs();
        return {14'd0, training_hdc_model, binarizing_class_hvs, binarize_done,
                label_err, busy, bus.bin_valid, class_select_bits,
                bus.binarized_class_counter, bus.bin_word_addr};
    endfunction

    task automatic enter_binarize();
        clear_inputs();
        start_train = 1'b1;
        tick();
        start_train       = 1'b0;
        train_label_valid = 1'b1;
        train_label       = 5'd2;
        train_last        = 1'b1;
        tick();
        clear_inputs();
        chk("enter_bin", {bus.bin_valid, binarizing_class_hvs, 5'(bus.binarized_class_counter), 2'(bus.bin_word_addr)},
            {1'b1, 1'b1, 5'd0, 2'd0});
    endtask

    // Sweep from (0,0) to completion against a (class, word) model.
    task automatic sweep(input bit random_ready);
        int  ec = 0;
        int  ew = 0;
        int  xfers = 0;
        int  cyc = 0;
        bit  done_seen = 1'b0;
        bit  rdy;
        bit  exp_done;
        while (!done_seen && cyc < 2000) begin
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.bin_ready = rdy;
            exp_done = rdy && (ec == NC - 1) && (ew == WPC - 1);
            tick();
            cyc++;
            if (rdy) xfers++;
            if (exp_done) begin
                done_seen = 1'b1;
                chk("sweep_done", {binarize_done, bus.bin_valid, busy, 5'(bus.binarized_class_counter), 2'(bus.bin_word_addr)},
                    {1'b1, 1'b0, 1'b1, 5'(NC - 1), 2'(WPC - 1)});
            end else begin
                if (rdy) begin
                    if (ew == WPC - 1) begin
                        ew = 0;
                        ec++;
                    end else begin
                        ew++;
                    end
                end
                chk("sweep_addr", {binarize_done, bus.bin_valid, 5'(bus.binarized_class_counter), 2'(bus.bin_word_addr)},
                    {1'b0, 1'b1, 5'(ec), 2'(ew)});
            end
        end
        chk("sweep_finished", 32'(done_seen), 32'd1);
        chk("sweep_xfers", 32'(xfers), 32'(NC * WPC));
        if (!random_ready) chk("sweep_cycles", 32'(cyc), 32'(NC * WPC));
        bus.bin_ready = 1'b0;
        tick();
        chk("after_done_idle", all_outputs(), 32'd0);
        tick();
        chk("no_second_done", 32'(binarize_done), 32'd0);
    endtask

    initial begin
        bus.bin_ready = 1'b0;

        //                 st  ab  vld lbl    lst rdy  trn bin bsy cls    err bv
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd25, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd25, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd26, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd25, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd30, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd25, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd25, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("reset_outputs", all_outputs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", all_outputs(), 32'd0);

        // Training-phase vectors
        for (int i = 0; i < 11; i++) begin
            start_train       = vecs[i].st;
            abort             = vecs[i].ab;
            train_label_valid = vecs[i].vld;
            train_label       = vecs[i].lbl;
            train_last        = vecs[i].lst;
            bus.bin_ready     = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d", i),
                {training_hdc_model, binarizing_class_hvs, busy, 5'(class_select_bits),
                 label_err, bus.bin_valid, 5'(bus.binarized_class_counter), 2'(bus.bin_word_addr)},
                {vecs[i].e_train, vecs[i].e_bin, vecs[i].e_busy, 5'(vecs[i].e_cls),
                 vecs[i].e_err, vecs[i].e_bvalid, 5'd0, 2'd0});
        end
        clear_inputs();

        // Full sweep with ready held high, then with random backpressure
        sweep(1'b0);
        enter_binarize();
        sweep(1'b1);

        // Abort at class 1, word 2
        enter_binarize();
        bus.bin_ready = 1'b1;
        for (int i = 0; i < WPC + 2; i++) tick();
        chk("pre_abort_addr", {5'(bus.binarized_class_counter), 2'(bus.bin_word_addr)}, {5'd1, 2'd2});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.bin_ready = 1'b0;
        chk("abort_idle", all_outputs(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", {binarize_done, busy}, 2'b00);
        end
        enter_binarize();
        sweep(1'b0);

        // Asynchronous reset mid-sweep
        enter_binarize();
        bus.bin_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", all_outputs(), 32'd0);
        tick();
        chk("reset_held", all_outputs(), 32'd0);
        #2;
        rst_n = 1'b1;
        bus.bin_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_quiet", all_outputs(), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
